// File: rtl/reg_file.sv
// Renaming register file: per-register value, busy bit and ROB tag; lookups are combinational with commit bypass.
// Zero-latency lookup; state updates on posedge clk only while rdy=1 (rdy=0 holds all state).
module reg_file #(
    parameter int REG_NUM   = 32,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 Dis_flag,
    input  logic [4:0]           Dis_rd,
    input  logic [ROB_IDX_W-1:0] Dis_ROB_idx,
    input  logic [4:0]           Dis_rs1,
    input  logic [4:0]           Dis_rs2,
    output logic                 Dis_Q1_flag,
    output logic                 Dis_Q2_flag,
    output logic [ROB_IDX_W-1:0] Dis_Q1,
    output logic [ROB_IDX_W-1:0] Dis_Q2,
    output logic [31:0]          Dis_V1,
    output logic [31:0]          Dis_V2,
    input  logic                 ROB_write_flag,
    input  logic [4:0]           ROB_rd,
    input  logic [ROB_IDX_W-1:0] ROB_ROB_idx,
    input  logic [31:0]          ROB_val,
    input  logic                 ROB_roll
);

    logic [31:0]          val_q  [REG_NUM];
    logic [31:0]          val_d  [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_q  [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_d  [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [REG_NUM-1:0]   busy_d;

    logic [4:0]           rs     [2];
    logic                 lk_flag[2];
    logic [ROB_IDX_W-1:0] lk_q   [2];
    logic [31:0]          lk_v   [2];

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy) begin
            // Only the matching rename is retired; a newer rename of the same rd stays busy.
            if (ROB_write_flag && ROB_rd != 5'd0) begin
                val_d[ROB_rd] = ROB_val;
                if (busy_q[ROB_rd] && tag_q[ROB_rd] == ROB_ROB_idx)
                    busy_d[ROB_rd] = 1'b0;
            end
            if (ROB_roll) begin
                busy_d = '0;
                for (int i = 0; i < REG_NUM; i++)
                    tag_d[i] = '0;
            end else if (Dis_flag && Dis_rd != 5'd0) begin
                busy_d[Dis_rd] = 1'b1;
                tag_d[Dis_rd]  = Dis_ROB_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            val_q  <= val_d;
            tag_q  <= tag_d;
        end
    end

    // Lookups see held state plus the commit bypass, never this cycle's rename.
    always_comb begin
        rs[0] = Dis_rs1;
        rs[1] = Dis_rs2;
        for (int p = 0; p < 2; p++) begin
            lk_flag[p] = 1'b0;
            lk_q[p]    = '0;
            lk_v[p]    = '0;
            if (rs[p] != 5'd0) begin
                if (!busy_q[rs[p]]) begin
                    lk_v[p] = val_q[rs[p]];
                end else if (ROB_write_flag && ROB_rd == rs[p] &&
                             tag_q[rs[p]] == ROB_ROB_idx) begin
                    lk_v[p] = ROB_val;
                end else begin
                    lk_flag[p] = 1'b1;
                    lk_q[p]    = tag_q[rs[p]];
                end
            end
        end
    end

    assign Dis_Q1_flag = lk_flag[0];
    assign Dis_Q1      = lk_q[0];
    assign Dis_V1      = lk_v[0];
    assign Dis_Q2_flag = lk_flag[1];
    assign Dis_Q2      = lk_q[1];
    assign Dis_V2      = lk_v[1];

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers (x0..x31).
REQ-002 SHALL have parameter ROB_IDX_W, default 4, width of a ROB tag (16 ROB entries).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rdy  input  1  global ready; low means freeze all state.
REQ-006 SHALL have ports Dis_flag  input  1 and Dis_rd  input  5: dispatch renames Dis_rd to a new ROB entry.
REQ-007 SHALL have port Dis_ROB_idx  input  ROB_IDX_W  ROB tag allocated to the dispatching instruction.
REQ-008 SHALL have ports Dis_rs1 and Dis_rs2  input  5  source register indices to look up.
REQ-009 SHALL have ports Dis_Q1_flag and Dis_Q2_flag  output  1  source pending on an in-flight producer.
REQ-010 SHALL have ports Dis_Q1 and Dis_Q2  output  ROB_IDX_W  producer ROB tag, valid when the matching flag is 1, else 0.
REQ-011 SHALL have ports Dis_V1 and Dis_V2  output  32  source value, valid when the matching flag is 0, else 0.
REQ-012 SHALL have ports ROB_write_flag  input  1, ROB_rd  input  5, ROB_ROB_idx  input  ROB_IDX_W, ROB_val  input  32: commit write from the ROB.
REQ-013 SHALL have port ROB_roll  input  1  misprediction flush.

Function
REQ-014 SHALL hold per register: val[31:0], busy (1 bit), tag[ROB_IDX_W-1:0].
REQ-015 Lookup SHALL be combinational on current state plus same-cycle commit bypass; no latency.
REQ-016 Lookup for rsN == 0 SHALL return flag 0, Q 0, V 0.
REQ-017 Lookup for nonzero rsN with busy=0 SHALL return flag 0, V = val[rsN].
REQ-018 Lookup for busy rsN whose tag equals ROB_ROB_idx while ROB_write_flag=1 and ROB_rd=rsN SHALL return flag 0, V = ROB_val (bypass).
REQ-019 Otherwise busy rsN SHALL return flag 1, Q = tag[rsN], V = 0.
REQ-020 Lookup SHALL NOT reflect the same-cycle dispatch rename (an instruction never depends on its own rd).
REQ-021 On posedge with rdy=1 and ROB_write_flag=1 and ROB_rd != 0, val[ROB_rd] SHALL take ROB_val.
REQ-022 The commit SHALL clear busy[ROB_rd] only if busy is set and tag[ROB_rd] == ROB_ROB_idx (a newer rename survives).
REQ-023 On posedge with rdy=1, Dis_flag=1, ROB_roll=0 and Dis_rd != 0, busy[Dis_rd] SHALL become 1 and tag[Dis_rd] SHALL become Dis_ROB_idx.
REQ-024 Dispatch and commit to the same register in one cycle: commit value SHALL be written; busy SHALL stay 1 with tag = Dis_ROB_idx.
REQ-025 ROB_roll=1 (with rdy=1) SHALL clear every busy bit and tag to 0; Dis_flag SHALL be ignored that cycle.
REQ-026 A commit write coincident with ROB_roll SHALL still update val (committing JALR).
REQ-027 Register x0 SHALL always read val 0, busy 0; writes and renames to x0 SHALL be dropped.
REQ-028 With rdy=0, no state SHALL change; lookups SHALL remain combinational on held state.

Reset
REQ-029 While rst=1 at posedge, all val, busy and tag SHALL become 0, taking priority over roll, commit and dispatch.
REQ-030 After reset, every lookup SHALL return flag 0, Q 0, V 0 until a commit writes a nonzero register.

Verification
REQ-031 Commit x5=0x12345678 tag 3 after reset -> next cycle rs1=5 gives Q1_flag 0, V1 0x12345678.
REQ-032 Dispatch rd=7 tag 2, then rs2=7 -> Q2_flag 1, Q2 2; same cycle commit rd=7 tag 2 val 0xAB -> bypass V2 0xAB, flag 0; next cycle busy cleared.
REQ-033 Rename x9 tag 1, rename x9 tag 4, commit x9 tag 1 val 5 -> val[9]=5, rs1=9 still Q1_flag 1, Q1 4.
REQ-034 Rename x3 tag 6 and x4 tag 7, assert ROB_roll with commit x10 val 0x40 plus Dis_flag rd=11 -> x3, x4, x11 not busy; x10 reads 0x40.
REQ-035 Commit rd=0 val 0xFFFF and dispatch rd=0 -> rs1=0 reads flag 0, V 0.
REQ-036 Hold rdy=0 with commit x2 val 9 and dispatch rd=2 -> no change; rst mid-sequence with pending busy -> all lookups flag 0, V 0.
